// File: rtl/imm_gen_pkg.sv
// Shared encodings for the RV32 immediate generator: format selects, opcodes, funct3 shift codes.
package imm_gen_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_AUTO  = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

endpackage

// File: rtl/imm_gen_fmt_dec.sv
// Opcode/funct3 to immediate-format decoder for the AUTO select; flags opcodes with no immediate.
// Latency: combinational. Backpressure: none. ZIMM mapping controlled by IMM_GEN_ZIMM_EN.
module imm_gen_fmt_dec
  import imm_gen_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output imm_fmt_e   fmt,
  output logic       err
);

  always_comb begin
    fmt = IMM_I;
    err = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_OPIMM: begin
        if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) fmt = IMM_SHAMT;
        else                                          fmt = IMM_I;
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
        // csrr*i forms carry the zero-extended immediate in the rs1 field
        if (funct3[2]) fmt = IMM_ZIMM;
        else           fmt = IMM_I;
`else
        fmt = IMM_I;
`endif
      end
      OPC_STORE:           fmt = IMM_S;
      OPC_BRANCH:          fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:  fmt = IMM_U;
      OPC_JAL:             fmt = IMM_J;
      default:             err = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen.sv
// RV32 immediate generator: selects/decodes a format and extracts the immediate by bit selection.
// Latency: 1 cycle, one request per cycle. Backpressure: none; optional ZIMM via IMM_GEN_ZIMM_EN.
module imm_gen
  import imm_gen_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] instr,
  input  logic [2:0]      imm_sel,
  input  logic            in_valid,
  output logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic            imm_err
);

  imm_fmt_e        dec_fmt;
  logic            dec_err;
  imm_fmt_e        fmt;
  logic            fmt_err;
  logic [XLEN-1:0] imm_nxt;
  logic            err_nxt;

  logic [XLEN-1:0] imm_d, imm_q;
  logic            err_d, err_q;
  logic            vld_d, vld_q;

  imm_gen_fmt_dec u_fmt_dec (
    .opcode (instr[6:0]),
    .funct3 (instr[14:12]),
    .fmt    (dec_fmt),
    .err    (dec_err)
  );

  always_comb begin
    fmt     = imm_fmt_e'(imm_sel);
    fmt_err = 1'b0;
    if (imm_fmt_e'(imm_sel) == IMM_AUTO) begin
      fmt     = dec_fmt;
      fmt_err = dec_err;
    end
  end

  // Pure wiring: every format is a selection/concatenation plus replication of the sign bit.
  always_comb begin
    imm_nxt = '0;
    err_nxt = fmt_err;
    if (!fmt_err) begin
      case (fmt)
        IMM_I:     imm_nxt = {{20{instr[31]}}, instr[31:20]};
        IMM_S:     imm_nxt = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        IMM_B:     imm_nxt = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        IMM_U:     imm_nxt = {instr[31:12], 12'b0};
        IMM_J:     imm_nxt = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        IMM_SHAMT: imm_nxt = {27'b0, instr[24:20]};
`ifdef IMM_GEN_ZIMM_EN
        IMM_ZIMM:  imm_nxt = {27'b0, instr[19:15]};
`endif
        default:   err_nxt = 1'b1;
      endcase
    end
  end

  always_comb begin
    vld_d = in_valid;
    imm_d = imm_q;
    err_d = err_q;
    if (in_valid) begin
      imm_d = imm_nxt;
      err_d = err_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imm_q <= '0;
      err_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      imm_q <= imm_d;
      err_q <= err_d;
      vld_q <= vld_d;
    end
  end

  assign imm       = imm_q;
  assign imm_err   = err_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_imm_gen.sv
// Directed-vector bench for imm_gen; expected immediates are hand-decoded constants.
module tb_imm_gen;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic        in_valid;
  logic [31:0] imm;
  logic        out_valid;
  logic        imm_err;

  int n_cmp = 0;
  int n_bad = 0;

  imm_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .instr     (instr),
    .imm_sel   (imm_sel),
    .in_valid  (in_valid),
    .imm       (imm),
    .out_valid (out_valid),
    .imm_err   (imm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e_imm, input logic e_err,
                            input logic e_vld);
    check({tag, ".imm"}, imm, e_imm);
    check({tag, ".err"}, {31'b0, imm_err}, {31'b0, e_err});
    check({tag, ".vld"}, {31'b0, out_valid}, {31'b0, e_vld});
  endtask

  // Present one request at the falling edge; sample just after the capturing rising edge.
  task automatic step(input logic [31:0] i, input logic [2:0] s, input logic v);
    @(negedge clk);
    instr    = i;
    imm_sel  = s;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    instr    = '0;
    imm_sel  = '0;
    in_valid = 1'b0;
    #1;
    expect_out("reset", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    step(32'hFFF00093, 3'd0, 1'b1); expect_out("i_neg1",       32'hFFFFFFFF, 1'b0, 1'b1);
    step(32'hFE20AE23, 3'd7, 1'b1); expect_out("auto_s",       32'hFFFFFFFC, 1'b0, 1'b1);
    step(32'hFE000CE3, 3'd2, 1'b1); expect_out("b_neg8",       32'hFFFFFFF8, 1'b0, 1'b1);
    step(32'h123450B7, 3'd7, 1'b1); expect_out("auto_lui",     32'h12345000, 1'b0, 1'b1);
    step(32'h0010006F, 3'd4, 1'b1); expect_out("j_800",        32'h00000800, 1'b0, 1'b1);
    step(32'h002081B3, 3'd7, 1'b1); expect_out("auto_rtype",   32'h00000000, 1'b1, 1'b1);
    step(32'h40F0D093, 3'd7, 1'b1); expect_out("auto_srai",    32'h0000000F, 1'b0, 1'b1);
`ifdef IMM_GEN_ZIMM_EN
    step(32'h0002D073, 3'd6, 1'b1); expect_out("zimm_sel",     32'h00000005, 1'b0, 1'b1);
    step(32'h0002D073, 3'd7, 1'b1); expect_out("auto_csrwi",   32'h00000005, 1'b0, 1'b1);
`else
    step(32'h0002D073, 3'd6, 1'b1); expect_out("zimm_sel",     32'h00000000, 1'b1, 1'b1);
    step(32'h0002D073, 3'd7, 1'b1); expect_out("auto_csrwi",   32'h00000000, 1'b0, 1'b1);
`endif
    step(32'h00112423, 3'd1, 1'b1); expect_out("s_pos8",       32'h00000008, 1'b0, 1'b1);
    step(32'h7FF12083, 3'd7, 1'b1); expect_out("auto_load",    32'h000007FF, 1'b0, 1'b1);
    step(32'h80008067, 3'd7, 1'b1); expect_out("auto_jalr",    32'hFFFFF800, 1'b0, 1'b1);
    step(32'hFFF09093, 3'd7, 1'b1); expect_out("auto_slli",    32'h0000001F, 1'b0, 1'b1);
    step(32'hFFF00093, 3'd7, 1'b1); expect_out("auto_addi",    32'hFFFFFFFF, 1'b0, 1'b1);
    step(32'hFFF00093, 3'd5, 1'b1); expect_out("shamt_sel",    32'h0000001F, 1'b0, 1'b1);
    step(32'hFFF00093, 3'd3, 1'b1); expect_out("u_sel",        32'hFFF00000, 1'b0, 1'b1);
    step(32'h00001017, 3'd7, 1'b1); expect_out("auto_auipc",   32'h00001000, 1'b0, 1'b1);
    step(32'h00000463, 3'd7, 1'b1); expect_out("auto_beq",     32'h00000008, 1'b0, 1'b1);
    step(32'h00100073, 3'd7, 1'b1); expect_out("auto_ebreak",  32'h00000001, 1'b0, 1'b1);
    step(32'h8000006F, 3'd7, 1'b1); expect_out("auto_jal_neg", 32'hFFF00000, 1'b0, 1'b1);

    // Idle cycles: out_valid drops, imm/imm_err hold.
    step(32'h002081B3, 3'd7, 1'b0); expect_out("hold_imm",     32'hFFF00000, 1'b0, 1'b0);
    step(32'h002081B3, 3'd7, 1'b1); expect_out("err_again",    32'h00000000, 1'b1, 1'b1);
    step(32'hFFF00093, 3'd0, 1'b0); expect_out("hold_err",     32'h00000000, 1'b1, 1'b0);
    step(32'hFFF00093, 3'd0, 1'b1); expect_out("pre_reset",    32'hFFFFFFFF, 1'b0, 1'b1);

    // Asynchronous reset between edges with a request in flight.
    @(negedge clk);
    instr    = 32'h123450B7;
    imm_sel  = 3'd7;
    in_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("async_rst", 32'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    expect_out("in_rst", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("post_rst_idle", 32'h0, 1'b0, 1'b0);

    step(32'h0010006F, 3'd4, 1'b1); expect_out("first_after",  32'h00000800, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
